// File: rtl/ddr2_af_cmd_arbiter_0.sv
// Two-port round-robin command arbiter feeding the DDR2 address FIFO.
// Ownership is held for bounded, page-aware bursts and always drains via IDLE.
module ddr2_af_cmd_arbiter_0 #(
  parameter int MAX_BURST = 4,
  parameter int RB_LSB    = 10
) (
  input  logic        clk0,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        a_valid,
  input  logic [2:0]  a_cmd,
  input  logic [27:0] a_addr,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [2:0]  b_cmd,
  input  logic [27:0] b_addr,
  output logic        b_ready,
  input  logic        af_almost_full,
  output logic [35:0] app_af_addr,
  output logic        app_af_wren,
  output logic [1:0]  grant_owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t      state, state_n;
  logic [3:0]  burst_cnt, burst_cnt_n, cnt_inc;
  logic [15:0] last_rb, last_rb_n, x_rb;
  logic        last_served, last_served_n;
  logic        own_b, x_valid, o_valid, x_ready, xfer, miss;
  logic [2:0]  x_cmd;
  logic [27:0] x_addr;

  // Owner-relative view of the two ports
  assign own_b   = (state == OWN_B);
  assign x_valid = own_b ? b_valid : a_valid;
  assign o_valid = own_b ? a_valid : b_valid;
  assign x_cmd   = own_b ? b_cmd : a_cmd;
  assign x_addr  = own_b ? b_addr : a_addr;

  assign x_ready = (state != IDLE) & ~af_almost_full & init_done;
  assign a_ready = (state == OWN_A) & x_ready;
  assign b_ready = own_b & x_ready;
  assign xfer    = x_valid & x_ready;

  assign x_rb    = x_addr[RB_LSB+15:RB_LSB];
  assign cnt_inc = burst_cnt + 4'd1;
  // Yield on a page change only when someone else is waiting
  assign miss    = (burst_cnt != 4'd0) & (x_rb != last_rb) & o_valid;

  assign grant_owner = state;

  always_comb begin
    state_n       = state;
    burst_cnt_n   = burst_cnt;
    last_rb_n     = last_rb;
    last_served_n = last_served;
    unique case (state)
      IDLE: begin
        if (init_done) begin
          if (a_valid && b_valid)
            state_n = last_served ? OWN_A : OWN_B;
          else if (a_valid)
            state_n = OWN_A;
          else if (b_valid)
            state_n = OWN_B;
        end
      end
      OWN_A, OWN_B: begin
        if (!init_done) begin
          state_n     = IDLE;
          burst_cnt_n = 4'd0;
        end else if (!x_valid) begin
          state_n       = IDLE;
          burst_cnt_n   = 4'd0;
          last_served_n = own_b;
        end else if (xfer) begin
          last_rb_n = x_rb;
          if (cnt_inc == MAX_CNT || miss) begin
            state_n       = IDLE;
            burst_cnt_n   = 4'd0;
            last_served_n = own_b;
          end else begin
            burst_cnt_n = cnt_inc;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      burst_cnt   <= 4'd0;
      last_rb     <= 16'd0;
      last_served <= 1'b1;
      app_af_wren <= 1'b0;
      app_af_addr <= 36'd0;
    end else begin
      state       <= state_n;
      burst_cnt   <= burst_cnt_n;
      last_rb     <= last_rb_n;
      last_served <= last_served_n;
      app_af_wren <= xfer;
      if (xfer)
        app_af_addr <= {4'b0000, x_cmd, 1'b0, x_addr};
    end
  end

endmodule

// File: tb/tb_ddr2_af_cmd_arbiter_0.sv
// Randomized scoreboard bench for ddr2_af_cmd_arbiter_0.
// A policy model predicts grants and FIFO words; a monitor checks writes.
module tb_ddr2_af_cmd_arbiter_0;

  localparam int MAXB = 4;
  localparam int RBL  = 10;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [27:0] addr;
  } cmd_t;

  logic        clk0 = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [2:0]  a_cmd = '0, b_cmd = '0;
  logic [27:0] a_addr = '0, b_addr = '0;
  logic        af_almost_full = 1'b0;
  logic        a_ready, b_ready, app_af_wren;
  logic [35:0] app_af_addr;
  logic [1:0]  grant_owner;

  int errors = 0;
  int checks = 0;

  cmd_t        aq[$], bq[$];
  logic [35:0] sb[$], wlog[$];
  logic [35:0] last_word = '0;
  int          glog[$];
  bit          log_on = 0;
  int          tie_exp[6] = '{0, 1, 0, 2, 0, 1};

  bit rst_set = 0, init_set = 0, af_set = 0;
  bit a_en = 1, b_en = 1, rnd = 0;

  // Policy model: owner 0 none / 1 A / 2 B, rr 0=A last / 1=B last
  int          own = 0, taken = 0, rr = 1;
  logic [15:0] prev_rb = '0;

  always #5 clk0 = ~clk0;

  ddr2_af_cmd_arbiter_0 #(.MAX_BURST(MAXB), .RB_LSB(RBL)) dut (
    .clk0(clk0), .rst_n(rst_n), .init_done(init_done),
    .a_valid(a_valid), .a_cmd(a_cmd), .a_addr(a_addr), .a_ready(a_ready),
    .b_valid(b_valid), .b_cmd(b_cmd), .b_addr(b_addr), .b_ready(b_ready),
    .af_almost_full(af_almost_full), .app_af_addr(app_af_addr),
    .app_af_wren(app_af_wren), .grant_owner(grant_owner)
  );

  task automatic chk(input string name, input logic [35:0] act,
                     input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic [2:0] c, input int row, input int col);
    cmd_t r;
    r.cmd  = c;
    r.addr = 28'((row << RBL) | col);
    return r;
  endfunction

  function automatic logic [35:0] fmt(input cmd_t c);
    return {4'b0000, c.cmd, 1'b0, c.addr};
  endfunction

  task automatic model_step();
    bit av, bv, xv, ov, miss;
    cmd_t xc;
    logic [15:0] rb;
    av = a_valid;
    bv = b_valid;
    if (!rst_n) begin
      own = 0; taken = 0; prev_rb = '0; rr = 1;
      return;
    end
    if (own == 0) begin
      if (init_done) begin
        if (av && bv) own = (rr == 1) ? 1 : 2;
        else if (av) own = 1;
        else if (bv) own = 2;
      end
      return;
    end
    xv = (own == 1) ? av : bv;
    ov = (own == 1) ? bv : av;
    if (!init_done) begin
      own = 0; taken = 0;
      return;
    end
    if (!xv) begin
      rr = own - 1; own = 0; taken = 0;
      return;
    end
    if (af_almost_full) return;
    xc = (own == 1) ? aq.pop_front() : bq.pop_front();
    sb.push_back(fmt(xc));
    rb = xc.addr[RBL+15:RBL];
    miss = (taken > 0) && (rb != prev_rb) && ov;
    taken++;
    prev_rb = rb;
    if (taken == MAXB || miss) begin
      rr = own - 1; own = 0; taken = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk0);
    rst_n = rst_set;
    init_done = init_set;
    if (rnd) begin
      a_en   = ($urandom_range(0, 7) != 0);
      b_en   = ($urandom_range(0, 7) != 0);
      af_set = ($urandom_range(0, 5) == 0);
    end
    af_almost_full = af_set;
    a_valid = a_en && (aq.size() > 0);
    if (aq.size() > 0) begin a_cmd = aq[0].cmd; a_addr = aq[0].addr; end
    b_valid = b_en && (bq.size() > 0);
    if (bq.size() > 0) begin b_cmd = bq[0].cmd; b_addr = bq[0].addr; end
    #1;
    if (rst_n) begin
      chk("grant", 36'(grant_owner), 36'(own));
      chk("a_ready", 36'(a_ready), 36'(own == 1 && !af_set && init_set));
      chk("b_ready", 36'(b_ready), 36'(own == 2 && !af_set && init_set));
      if (log_on && (glog.size() == 0 || glog[$] != int'(grant_owner)))
        glog.push_back(int'(grant_owner));
    end
    @(posedge clk0);
    model_step();
  endtask

  // Monitor: every FIFO write must match the oldest predicted word
  initial begin : mon
    bit afs;
    forever begin
      @(posedge clk0);
      afs = af_almost_full;
      #2;
      if (rst_n !== 1'b1) continue;
      if (app_af_wren) begin
        chk("af_rule", 36'(afs), 36'd0);
        wlog.push_back(app_af_addr);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got %h expected none", app_af_addr);
        end else begin
          last_word = sb.pop_front();
          chk("af_word", app_af_addr, last_word);
        end
      end else begin
        chk("af_hold", app_af_addr, last_word);
        if (sb.size() != 0) begin
          checks++; errors++;
          $display("FAIL missing_write: got none expected %h", sb[0]);
          sb.delete();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    #2;
    chk("rst_wren", 36'(app_af_wren), 36'd0);
    chk("rst_addr", app_af_addr, 36'd0);
    chk("rst_grant", 36'(grant_owner), 36'd0);
    chk("rst_a_ready", 36'(a_ready), 36'd0);
    chk("rst_b_ready", 36'(b_ready), 36'd0);
    repeat (2) cycle();
    rst_set = 1; init_set = 1;

    // Tie from reset, same row on both ports
    for (int i = 0; i < 20; i++) begin
      aq.push_back(mk(3'(4 + i % 2), 7, i));
      bq.push_back(mk(3'b101, 7, 100 + i));
    end
    log_on = 1;
    repeat (14) cycle();
    log_on = 0;
    if (glog.size() < 6) chk("tie_len", 36'(glog.size()), 36'd6);
    else for (int k = 0; k < 6; k++) chk("tie_seq", 36'(glog[k]), 36'(tie_exp[k]));
    aq.delete(); bq.delete();
    repeat (3) cycle();

    // Page-miss yield, then A alone runs full bursts
    wlog.delete();
    foreach (tie_exp[k]) aq.push_back(mk(3'b100, (k < 2) ? 5 : 9, k));
    cycle();
    for (int i = 0; i < 3; i++) bq.push_back(mk(3'b101, 1, 100 + i));
    repeat (20) cycle();
    if (wlog.size() < 4) chk("miss_len", 36'(wlog.size()), 36'd4);
    else begin
      chk("miss_last_a", wlog[2], fmt(mk(3'b100, 9, 2)));
      chk("miss_first_b", wlog[3], fmt(mk(3'b101, 1, 100)));
    end
    for (int i = 0; i < 6; i++) aq.push_back(mk(3'b100, i * 3, i));
    repeat (20) cycle();

    // Back-pressure mid-burst
    for (int i = 0; i < 8; i++) aq.push_back(mk(3'b101, 3, 200 + i));
    repeat (3) cycle();
    af_set = 1;
    repeat (6) cycle();
    af_set = 0;
    repeat (14) cycle();

    // Command word format
    wlog.delete();
    aq.push_back('{3'b101, 28'h0ABCDEF});
    repeat (4) cycle();
    if (wlog.size() < 1) chk("fmt_len", 36'(wlog.size()), 36'd1);
    else chk("fmt_word", wlog[0], 36'h0A0ABCDEF);

    // Reset during a B burst, then requests held off by init_done
    for (int i = 0; i < 8; i++) bq.push_back(mk(3'b100, 2, 300 + i));
    n = 0;
    while (!(own == 2 && taken >= 1) && n < 20) begin cycle(); n++; end
    #3;
    chk("own_b_grant", 36'(grant_owner), 36'd2);
    rst_n = 0; rst_set = 0;
    #1;
    chk("mid_rst_wren", 36'(app_af_wren), 36'd0);
    chk("mid_rst_addr", app_af_addr, 36'd0);
    chk("mid_rst_grant", 36'(grant_owner), 36'd0);
    chk("mid_rst_b_ready", 36'(b_ready), 36'd0);
    own = 0; taken = 0; prev_rb = '0; rr = 1;
    sb.delete(); aq.delete(); bq.delete();
    last_word = '0;
    init_set = 0;
    for (int i = 0; i < 4; i++) begin
      aq.push_back(mk(3'b101, 4, 400 + i));
      bq.push_back(mk(3'b100, 4, 500 + i));
    end
    repeat (2) cycle();
    rst_set = 1;
    repeat (4) cycle();
    init_set = 1;
    wlog.delete();
    repeat (14) cycle();
    if (wlog.size() < 1) chk("init_len", 36'(wlog.size()), 36'd1);
    else chk("init_first_a", wlog[0], fmt(mk(3'b101, 4, 400)));

    // Randomized traffic
    rnd = 1;
    for (int c = 0; c < 1500; c++) begin
      while (aq.size() < 3) begin
        cmd_t t = mk(3'($urandom_range(4, 5)), $urandom_range(0, 3),
                     $urandom_range(0, 1023));
        t.addr[27:26] = 2'($urandom_range(0, 3));
        aq.push_back(t);
      end
      while (bq.size() < 3) begin
        cmd_t t = mk(3'($urandom_range(4, 5)), $urandom_range(0, 3),
                     $urandom_range(0, 1023));
        t.addr[27:26] = 2'($urandom_range(0, 3));
        bq.push_back(t);
      end
      init_set = ($urandom_range(0, 49) != 0);
      cycle();
    end
    rnd = 0;
    a_en = 1; b_en = 1; af_set = 0; init_set = 1;
    repeat (60) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
